// File: rtl/pipeline_trace.sv
// pipeline_trace: trace capture for the 5-stage MIPS pipeline.
// Every cycle in ARMED/POST, {pc, instr_id, ans_wb} is written into a circular
// buffer. A pc match on trig_pc starts a post-trigger window of POST samples,
// after which the buffer freezes. A host then reads it out oldest-first, one
// 32-bit word per request, in the order pc, instr_id, ans_wb.
// Optional macro TRACE_NOP_FILTER_EN: samples with instr_id == 0 are dropped.
// They advance neither count nor the post counter, and they cannot trigger.
module pipeline_trace #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned POST  = 8
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [31:0]            pc,
  input  logic [31:0]            instr_id,
  input  logic [31:0]            ans_wb,
  input  logic                   arm,
  input  logic [31:0]            trig_pc,
  input  logic                   rd_req,
  output logic [31:0]            rd_data,
  output logic                   rd_valid,
  output logic                   rd_last,
  output logic [1:0]             state,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARMED = 2'd1,
    S_POST  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] post_q, post_d;
  logic [CW-1:0] rd_ent_q, rd_ent_d;
  logic [1:0]    rd_word_q, rd_word_d;
  logic          rd_end_q, rd_end_d;
  logic [31:0]   rd_data_q, rd_data_d;
  logic          rd_valid_q, rd_valid_d;
  logic          rd_last_q, rd_last_d;
  logic          wr_en;
  logic          keep;
  logic [AW-1:0] oldest;
  logic [AW-1:0] rd_addr;
  logic [95:0]   rd_entry;
  logic [31:0]   rd_word_sel;

  logic [95:0]   mem [DEPTH];

`ifdef TRACE_NOP_FILTER_EN
  assign keep = (instr_id != 32'h0);
`else
  assign keep = 1'b1;
`endif

  // Until the buffer has wrapped, the oldest entry is slot 0.
  assign oldest  = (count_q == CW'(DEPTH)) ? wr_ptr_q : '0;
  assign rd_addr = oldest + rd_ent_q[AW-1:0];

  // Select the word of the current readout entry.
  always_comb begin
    rd_entry = mem[rd_addr];
    case (rd_word_q)
      2'd0:    rd_word_sel = rd_entry[95:64];
      2'd1:    rd_word_sel = rd_entry[63:32];
      default: rd_word_sel = rd_entry[31:0];
    endcase
  end

  // Next-state, capture and readout control; a restart takes priority over everything else.
  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    post_d     = post_q;
    rd_ent_d   = rd_ent_q;
    rd_word_d  = rd_word_q;
    rd_end_d   = rd_end_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    rd_last_d  = 1'b0;
    wr_en      = 1'b0;
    if (arm) begin
      state_d   = S_ARMED;
      wr_ptr_d  = '0;
      count_d   = '0;
      post_d    = '0;
      rd_ent_d  = '0;
      rd_word_d = '0;
      rd_end_d  = 1'b0;
    end else begin
      case (state_q)
        S_ARMED, S_POST: begin
          if (keep) begin
            wr_en    = 1'b1;
            wr_ptr_d = wr_ptr_q + AW'(1);
            if (count_q != CW'(DEPTH)) count_d = count_q + CW'(1);
            if (state_q == S_ARMED) begin
              if (pc == trig_pc) begin
                post_d  = CW'(1);
                state_d = (POST == 1) ? S_DONE : S_POST;
              end
            end else begin
              post_d = post_q + CW'(1);
              if (post_d == CW'(POST)) state_d = S_DONE;
            end
          end
        end
        S_DONE: begin
          if (rd_req && !rd_end_q) begin
            rd_valid_d = 1'b1;
            rd_data_d  = rd_word_sel;
            if (rd_word_q == 2'd2) begin
              rd_word_d = 2'd0;
              rd_ent_d  = rd_ent_q + CW'(1);
              if (rd_ent_q == count_q - CW'(1)) begin
                rd_last_d = 1'b1;
                rd_end_d  = 1'b1;
              end
            end else begin
              rd_word_d = rd_word_q + 2'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Control and output registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= S_IDLE;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      post_q     <= '0;
      rd_ent_q   <= '0;
      rd_word_q  <= '0;
      rd_end_q   <= 1'b0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      rd_last_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      post_q     <= post_d;
      rd_ent_q   <= rd_ent_d;
      rd_word_q  <= rd_word_d;
      rd_end_q   <= rd_end_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      rd_last_q  <= rd_last_d;
    end
  end

  // Trace RAM; contents are never cleared.
  always_ff @(posedge clock) begin
    if (wr_en && !reset) mem[wr_ptr_q] <= {pc, instr_id, ans_wb};
  end

  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
  assign rd_last  = rd_last_q;
  assign state    = state_q;
  assign count    = count_q;

endmodule

// File: tb/tb_pipeline_trace.sv
// Bench for pipeline_trace: directed scenarios plus random traffic.
// All checks compare against a history-list reference model.
module tb_pipeline_trace;

  localparam int DEPTH = 16;
  localparam int POST  = 8;

  logic        clock;
  logic        reset;
  logic [31:0] pc, instr_id, ans_wb, trig_pc;
  logic        arm, rd_req;
  logic [31:0] rd_data;
  logic        rd_valid, rd_last;
  logic [1:0]  state;
  logic [4:0]  count;

  int total = 0;
  int bad   = 0;

  // Reference model: the last DEPTH kept samples, oldest first.
  logic [95:0] hist[$];
  int          m_state = 0;
  int          m_post  = 0;
  int          m_rd    = 0;
  logic [31:0] e_data  = 32'h0;
  bit          e_valid = 0;
  bit          e_last  = 0;

  pipeline_trace #(.DEPTH(DEPTH), .POST(POST)) dut (
    .clock(clock), .reset(reset), .pc(pc), .instr_id(instr_id), .ans_wb(ans_wb),
    .arm(arm), .trig_pc(trig_pc), .rd_req(rd_req), .rd_data(rd_data),
    .rd_valid(rd_valid), .rd_last(rd_last), .state(state), .count(count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic bit kept(input logic [31:0] ins);
`ifdef TRACE_NOP_FILTER_EN
    return ins != 32'h0;
`else
    return 1'b1;
`endif
  endfunction

  // Predict what the coming clock edge does with the inputs currently driven.
  function automatic void model_step();
    int cnt;
    logic [95:0] ent;
    e_valid = 0;
    e_last  = 0;
    if (reset) begin
      m_state = 0; m_post = 0; m_rd = 0; e_data = 32'h0; hist.delete();
    end else if (arm) begin
      m_state = 1; m_post = 0; m_rd = 0; hist.delete();
    end else if (m_state == 1 || m_state == 2) begin
      if (kept(instr_id)) begin
        hist.push_back({pc, instr_id, ans_wb});
        if (hist.size() > DEPTH) void'(hist.pop_front());
        if (m_state == 1) begin
          if (pc == trig_pc) begin
            m_post  = 1;
            m_state = (POST == 1) ? 3 : 2;
          end
        end else begin
          m_post++;
          if (m_post == POST) m_state = 3;
        end
      end
    end else if (m_state == 3 && rd_req) begin
      cnt = hist.size();
      if (m_rd < 3 * cnt) begin
        ent = hist[m_rd / 3];
        case (m_rd % 3)
          0:       e_data = ent[95:64];
          1:       e_data = ent[63:32];
          default: e_data = ent[31:0];
        endcase
        e_valid = 1;
        e_last  = (m_rd == 3 * cnt - 1);
        m_rd++;
      end
    end
  endfunction

  task automatic cyc();
    model_step();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) cyc();
    total++; if (state !== 2'd0) begin bad++; $display("FAIL reset_state: got %0d want 0", state); end
    total++; if (count !== 5'd0) begin bad++; $display("FAIL reset_count: got %0d want 0", count); end
    total++; if (rd_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", rd_valid); end
    total++; if (rd_last !== 1'b0) begin bad++; $display("FAIL reset_last: got %b want 0", rd_last); end
    total++; if (rd_data !== 32'h0) begin bad++; $display("FAIL reset_data: got %h want 0", rd_data); end
    reset = 1'b0;
    rd_req = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cyc();
      total++; if (rd_valid !== 1'b0) begin bad++; $display("FAIL idle_read_valid: got %b want 0", rd_valid); end
    end
    rd_req = 1'b0;
  endtask

  // Arm, stream pc = 0,4,8,..., wait for DONE, then read nreads words (optionally reset mid-readout).
  task automatic test_capture(input logic [31:0] trig, input int exp_cnt,
                              input logic [31:0] exp_first, input int nreads, input bit abort);
    trig_pc = trig;
    arm = 1'b1; rd_req = 1'b0;
    cyc();
    arm = 1'b0;
    total++; if (state !== 2'd1) begin bad++; $display("FAIL cap_arm_state: got %0d want 1", state); end
    total++; if (count !== 5'd0) begin bad++; $display("FAIL cap_arm_count: got %0d want 0", count); end
    for (int i = 0; i < 64 && m_state != 3; i++) begin
      pc = 32'(i * 4); instr_id = pc | 32'h1000; ans_wb = ~pc;
      cyc();
      total++; if (state !== 2'(m_state)) begin bad++; $display("FAIL cap_state: got %0d want %0d", state, m_state); end
      total++; if (count !== 5'(hist.size())) begin bad++; $display("FAIL cap_count: got %0d want %0d", count, hist.size()); end
    end
    total++; if (state !== 2'd3) begin bad++; $display("FAIL cap_done: got state %0d want 3 (timeout)", state); end
    total++; if (count !== 5'(exp_cnt)) begin bad++; $display("FAIL cap_final_count: got %0d want %0d", count, exp_cnt); end
    rd_req = 1'b1;
    for (int k = 0; k < nreads; k++) begin
      cyc();
      total++; if (rd_valid !== e_valid) begin bad++; $display("FAIL rd_valid: read %0d got %b want %b", k, rd_valid, e_valid); end
      total++; if (rd_data !== e_data) begin bad++; $display("FAIL rd_data: read %0d got %h want %h", k, rd_data, e_data); end
      total++; if (rd_last !== e_last) begin bad++; $display("FAIL rd_last: read %0d got %b want %b", k, rd_last, e_last); end
      if (k == 0) begin
        total++; if (rd_data !== exp_first) begin bad++; $display("FAIL rd_first: got %h want %h", rd_data, exp_first); end
      end
    end
    if (abort) begin
      rd_req = 1'b0; reset = 1'b1;
      cyc();
      reset = 1'b0;
      total++; if (state !== 2'd0) begin bad++; $display("FAIL midrd_reset_state: got %0d want 0", state); end
      total++; if (count !== 5'd0) begin bad++; $display("FAIL midrd_reset_count: got %0d want 0", count); end
      rd_req = 1'b1;
      for (int i = 0; i < 5; i++) begin
        cyc();
        total++; if (rd_valid !== 1'b0) begin bad++; $display("FAIL midrd_read_valid: got %b want 0", rd_valid); end
      end
    end else begin
      cyc();
      total++; if (rd_valid !== 1'b0) begin bad++; $display("FAIL rd_after_last: got %b want 0", rd_valid); end
    end
    rd_req = 1'b0;
  endtask

  task automatic test_restart();
    trig_pc = 32'h100;
    arm = 1'b1; rd_req = 1'b0;
    cyc();
    arm = 1'b0; rd_req = 1'b1;
    for (int i = 0; i < 5; i++) begin
      pc = 32'($urandom_range(0, 15) * 4); instr_id = $urandom | 32'h1; ans_wb = $urandom;
      cyc();
      total++; if (rd_valid !== 1'b0) begin bad++; $display("FAIL armed_read_valid: got %b want 0", rd_valid); end
      total++; if (state !== 2'd1) begin bad++; $display("FAIL armed_state: got %0d want 1", state); end
    end
    rd_req = 1'b0;
    pc = 32'h100; instr_id = 32'h1234; ans_wb = $urandom;
    cyc();
    total++; if (state !== 2'd2) begin bad++; $display("FAIL restart_trig: got %0d want 2", state); end
    for (int i = 0; i < 3; i++) begin
      pc = 32'($urandom_range(0, 15) * 4); instr_id = $urandom | 32'h1; ans_wb = $urandom;
      cyc();
    end
    arm = 1'b1;
    cyc();
    total++; if (state !== 2'd1) begin bad++; $display("FAIL restart_state: got %0d want 1", state); end
    total++; if (count !== 5'd0) begin bad++; $display("FAIL restart_count: got %0d want 0", count); end
    pc = 32'h100; instr_id = 32'h55; ans_wb = 32'hDEADBEEF;
    cyc();
    arm = 1'b0;
    total++; if (state !== 2'd1) begin bad++; $display("FAIL armtrig_state: got %0d want 1", state); end
    total++; if (count !== 5'd0) begin bad++; $display("FAIL armtrig_count: got %0d want 0", count); end
    for (int i = 0; i < 4; i++) begin
      pc = 32'($urandom_range(0, 15) * 4); instr_id = $urandom | 32'h1; ans_wb = $urandom;
      cyc();
    end
    pc = 32'h100; instr_id = 32'h77; ans_wb = $urandom;
    cyc();
    for (int i = 0; i < 40 && m_state != 3; i++) begin
      pc = 32'($urandom_range(0, 15) * 4); instr_id = $urandom | 32'h1; ans_wb = $urandom;
      cyc();
      total++; if (state !== 2'(m_state)) begin bad++; $display("FAIL restart_run_state: got %0d want %0d", state, m_state); end
    end
    total++; if (count !== 5'd12) begin bad++; $display("FAIL restart_final_count: got %0d want 12", count); end
    rd_req = 1'b1;
    for (int k = 0; k < 36; k++) begin
      cyc();
      total++; if (rd_valid !== e_valid) begin bad++; $display("FAIL restart_rd_valid: read %0d got %b want %b", k, rd_valid, e_valid); end
      total++; if (rd_data !== e_data) begin bad++; $display("FAIL restart_rd_data: read %0d got %h want %h", k, rd_data, e_data); end
      total++; if (rd_last !== e_last) begin bad++; $display("FAIL restart_rd_last: read %0d got %b want %b", k, rd_last, e_last); end
      total++; if (rd_data === 32'hDEADBEEF) begin bad++; $display("FAIL restart_absent: got %h want any other", rd_data); end
    end
    rd_req = 1'b0;
  endtask

`ifdef TRACE_NOP_FILTER_EN
  task automatic test_filter();
    int i;
    trig_pc = 32'hC;
    arm = 1'b1; rd_req = 1'b0;
    cyc();
    arm = 1'b0;
    for (i = 0; i < 20; i++) begin
      pc = 32'(i * 4); instr_id = i[0] ? 32'h0 : (pc | 32'h1000); ans_wb = ~pc;
      cyc();
      total++; if (state !== 2'd1) begin bad++; $display("FAIL filter_notrig: got %0d want 1", state); end
    end
    trig_pc = 32'h60;
    for (; i < 80 && m_state != 3; i++) begin
      pc = 32'(i * 4); instr_id = i[0] ? 32'h0 : (pc | 32'h1000); ans_wb = ~pc;
      cyc();
      total++; if (count !== 5'(hist.size())) begin bad++; $display("FAIL filter_count: got %0d want %0d", count, hist.size()); end
    end
    total++; if (state !== 2'd3 || count !== 5'd16) begin bad++; $display("FAIL filter_done: got state %0d count %0d want 3/16", state, count); end
    rd_req = 1'b1;
    for (int k = 0; k < 48; k++) begin
      cyc();
      total++; if (rd_data !== e_data || rd_valid !== e_valid) begin bad++; $display("FAIL filter_rd: read %0d got %h/%b want %h/%b", k, rd_data, rd_valid, e_data, e_valid); end
      if (k % 3 == 1) begin
        total++; if (rd_data === 32'h0) begin bad++; $display("FAIL filter_nop_read: got %h want nonzero", rd_data); end
      end
    end
    rd_req = 1'b0;
  endtask
`endif

  task automatic test_random();
    trig_pc = 32'h8;
    for (int n = 0; n < 3000; n++) begin
      reset  = ($urandom_range(0, 499) == 0);
      arm    = ($urandom_range(0, 39) == 0);
      rd_req = ($urandom_range(0, 3) != 0);
      pc       = 32'($urandom_range(0, 7) * 4);
      instr_id = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
      ans_wb   = $urandom;
      if ($urandom_range(0, 199) == 0) trig_pc = 32'($urandom_range(0, 7) * 4);
      cyc();
      total++; if (state !== 2'(m_state)) begin bad++; $display("FAIL rand_state: cyc %0d got %0d want %0d", n, state, m_state); end
      total++; if (count !== 5'(hist.size())) begin bad++; $display("FAIL rand_count: cyc %0d got %0d want %0d", n, count, hist.size()); end
      total++; if (rd_valid !== e_valid) begin bad++; $display("FAIL rand_valid: cyc %0d got %b want %b", n, rd_valid, e_valid); end
      total++; if (rd_data !== e_data) begin bad++; $display("FAIL rand_data: cyc %0d got %h want %h", n, rd_data, e_data); end
      if (e_valid) begin
        total++; if (rd_last !== e_last) begin bad++; $display("FAIL rand_last: cyc %0d got %b want %b", n, rd_last, e_last); end
      end
    end
    reset = 1'b0; arm = 1'b0; rd_req = 1'b0;
  endtask

  initial begin
    reset = 1'b1; arm = 1'b0; rd_req = 1'b0;
    pc = 32'h0; instr_id = 32'h0; ans_wb = 32'h0; trig_pc = 32'h0;
    test_reset();
    test_capture(32'h40, 16, 32'h20, 48, 1'b0);
    test_capture(32'h8, 10, 32'h0, 30, 1'b0);
    test_restart();
    test_capture(32'h40, 16, 32'h20, 7, 1'b1);
`ifdef TRACE_NOP_FILTER_EN
    test_filter();
`endif
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipeline_trace.md
# pipeline_trace

Hardware trace capture unit for the 5-stage MIPS pipeline. It reads the pipeline's observation outputs (`pc`, `instr_id`, `ans_wb`) every clock into a circular buffer, starting when it is armed. When `pc` matches a programmable trigger address, it keeps capturing for a fixed number of samples and then freezes. A host drains the frozen buffer oldest-first through a one-word-per-request read port. It sits beside `pipeline` at the top level and is the on-chip consumer of the same signals the bench monitors.

## Interface
- `DEPTH`, 16, buffer entries; power of two, ≥2.
- `POST`, 8, samples captured from the trigger onward, trigger sample included; 1 ≤ `POST` ≤ `DEPTH`.
- `clock`  in  1  system clock; rising edge.
- `reset`  in  1  synchronous, active-high.
- `pc`  in  32  pipeline PC output.
- `instr_id`  in  32  instruction in ID.
- `ans_wb`  in  32  writeback result.
- `arm`  in  1  single-cycle start/restart request.
- `trig_pc`  in  32  trigger address.
- `rd_req`  in  1  request the next readout word.
- `rd_data`  out  32  readout word.
- `rd_valid`  out  1  `rd_data` is valid this cycle.
- `rd_last`  out  1  final word of the final entry; qualified by `rd_valid`.
- `state`  out  2  IDLE=0, ARMED=1, POST=2, DONE=3.
- `count`  out  log2(DEPTH)+1  valid entries stored; saturates at `DEPTH`.

## Operation
- Each entry is 96 bits, stored as {`pc`, `instr_id`, `ans_wb`}. It is read out as three words, always in this order: word0 = `pc`, word1 = `instr_id`, word2 = `ans_wb`.
- IDLE:
  - Nothing is captured.
  - `arm` → ARMED. Write pointer, `count`, post counter and read pointer all clear to 0.
- ARMED:
  - Every cycle, the current sample is written at the write pointer. The pointer increments and wraps modulo `DEPTH`. `count` increments until it saturates.
  - If `pc == trig_pc`, that sample is the first post-trigger sample.
  - If `POST==1`, go directly to DONE; otherwise go to POST with post counter = 1.
- POST:
  - Capture continues.
  - When the post counter reaches `POST` on a write, go to DONE on that same edge.
  - `trig_pc` is ignored in this state.
- DONE:
  - The buffer is frozen.
  - Oldest entry index = 0 if `count < DEPTH`; otherwise it is the write pointer.
  - Each accepted `rd_req` returns the next word.
  - After the word with `rd_last`, further `rd_req` returns `rd_valid=0`.
- `arm` in any state restarts at ARMED with everything cleared. Buffer RAM is not cleared.
- Simultaneous `arm` and trigger in one cycle: `arm` wins. That cycle's sample is not captured.
- `rd_req` outside DONE is ignored: no state change and `rd_valid=0`.
- `reset` mid-capture or mid-readout: return to IDLE immediately. RAM contents are undefined but unreadable.

## Timing
- Reset values: `state=0`, `count=0`, `rd_data=0`, `rd_valid=0`, `rd_last=0`.
- Capture latency: an input sampled at edge N is in the buffer, and `count` reflects it, after edge N.
- `state` changes on the edge that writes the trigger sample (POST=1) or the final post sample.
- Read latency is 1:
  - `rd_req` high at edge N → `rd_data`, `rd_valid=1` after edge N, held for one cycle.
  - Back-to-back `rd_req` yields one word per cycle.
- `rd_valid` is low in any cycle that follows no accepted `rd_req`. `rd_data` holds its last value.
- A full readout takes `3*count` accepted requests.

## Configuration
- Macro: `TRACE_NOP_FILTER_EN`.
- Defined:
  - Samples with `instr_id == 32'h0` are not written.
  - They do not advance `count` or the post counter, and cannot trigger.
- Undefined: every sample in ARMED/POST is written, including NOPs.

## Test plan
- Reset check: assert `reset` for 3 cycles → `state=0`, `count=0`, `rd_valid=0`, `rd_last=0`. Drive `rd_req` for 5 cycles → `rd_valid` stays 0.
- Wrap-around with defaults:
  - Stimulus: pulse `arm`; `pc` = 0x0, 0x4, … one per cycle; `instr_id=pc|0x1000`; `ans_wb=~pc`; `trig_pc=0x40`.
  - DONE after the sample with pc 0x5C; `count=16`.
  - 48 reads give pc 0x20 … 0x5C in order, each with its matching `instr_id` and `ans_wb`. `rd_last` is set on read 48 only.
- Short run: same stimulus with `trig_pc=0x8` → DONE after pc 0x24; `count=10`; first word read 0x0; `rd_last` on read 30.
- Restart and ignored reads:
  - `rd_req` during ARMED → no `rd_valid`.
  - Pulse `arm` in POST at post counter 4 → `state=1`, `count=0`. A later trigger completes normally.
  - `arm` and trigger in the same cycle → that sample is absent from the buffer.
- Reset mid-readout: after 7 of 48 reads, assert `reset` → IDLE, `count=0`, further `rd_req` returns `rd_valid=0`.
- Filter (with `TRACE_NOP_FILTER_EN`): alternate `instr_id` 0 / nonzero, and hold `trig_pc` on a NOP cycle → no trigger. Retarget to a non-NOP pc → only non-NOP entries are read, with `count` equal to the number of non-NOP samples (≤16).
